// File: rtl/mul_unit_if.sv
// Request/response bundle between a requester and the shift-add multiplier.
// A start raised while busy=0 is taken on that edge. done/wr_en then pulse high for one cycle, and result/rd_out are valid in that cycle.
interface mul_unit_if;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_acc;
    logic        accumulate;
    logic        set_flags;
    logic [3:0]  rd_in;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [3:0]  rd_out;
    logic [31:0] result;
    logic        N;
    logic        Z;
    logic [1:0]  state_dbg;

    modport master (
        output start, op_a, op_b, op_acc, accumulate, set_flags, rd_in,
        input  busy, done, wr_en, rd_out, result, N, Z, state_dbg
    );

    modport slave (
        input  start, op_a, op_b, op_acc, accumulate, set_flags, rd_in,
        output busy, done, wr_en, rd_out, result, N, Z, state_dbg
    );
endinterface

// File: rtl/mul_unit.sv
// Iterative 32x32->32 shift-add multiplier with optional accumulate (MUL/MLA).
// It takes one multiplier bit per cycle and can optionally stop early when the remaining multiplier bits are zero.
module mul_unit #(
    parameter int EARLY_TERM = 0
) (
    input  logic         Clk,
    input  logic         Clr,
    mul_unit_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;
    logic [5:0]  r_cnt;
    logic [3:0]  r_rd;
    logic        r_sflags;
    logic        r_busy;
    logic        r_done;
    logic [3:0]  r_rd_out;
    logic [31:0] r_result;
    logic        r_n;
    logic        r_z;

    logic [31:0] w_acc_next;
    logic [31:0] w_mplier_next;
    logic [5:0]  w_cnt_next;
    logic        w_last;

    always_comb begin
        w_acc_next    = r_acc + (r_mplier[0] ? r_mcand : 32'd0);
        w_mplier_next = {1'b0, r_mplier[31:1]};
        w_cnt_next    = r_cnt + 6'd1;
        // Early exit looks at the multiplier after this edge's shift, so op_b=0 still costs one edge.
        w_last        = (w_cnt_next == 6'd32) ||
                        ((EARLY_TERM != 0) && (w_mplier_next == 32'd0));
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_state  <= S_IDLE;
            r_mcand  <= 32'd0;
            r_mplier <= 32'd0;
            r_acc    <= 32'd0;
            r_cnt    <= 6'd0;
            r_rd     <= 4'd0;
            r_sflags <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rd_out <= 4'd0;
            r_result <= 32'd0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_mcand  <= bus.op_a;
                        r_mplier <= bus.op_b;
                        r_rd     <= bus.rd_in;
                        r_sflags <= bus.set_flags;
                        r_acc    <= bus.accumulate ? bus.op_acc : 32'd0;
                        r_cnt    <= 6'd0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= {r_mcand[30:0], 1'b0};
                    r_mplier <= w_mplier_next;
                    r_cnt    <= w_cnt_next;
                    if (w_last) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_acc_next;
                        r_rd_out <= r_rd;
                        if (r_sflags) begin
                            r_n <= w_acc_next[31];
                            r_z <= (w_acc_next == 32'd0);
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.wr_en     = r_done;
    assign bus.rd_out    = r_rd_out;
    assign bus.result    = r_result;
    assign bus.N         = r_n;
    assign bus.Z         = r_z;
    assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_mul_unit.sv
// Bench for mul_unit: a fixed-latency and an early-terminating instance share the same stimulus.
// A per-cycle reference model and hand-computed vectors check both instances.
module tb_mul_unit;

    logic        Clk;
    logic        Clr;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op_acc;
    logic        accumulate;
    logic        set_flags;
    logic [3:0]  rd_in;

    int n_checks;
    int n_errors;

    mul_unit_if ifc0 ();
    mul_unit_if ifc1 ();

    assign ifc0.start      = start;
    assign ifc0.op_a       = op_a;
    assign ifc0.op_b       = op_b;
    assign ifc0.op_acc     = op_acc;
    assign ifc0.accumulate = accumulate;
    assign ifc0.set_flags  = set_flags;
    assign ifc0.rd_in      = rd_in;
    assign ifc1.start      = start;
    assign ifc1.op_a       = op_a;
    assign ifc1.op_b       = op_b;
    assign ifc1.op_acc     = op_acc;
    assign ifc1.accumulate = accumulate;
    assign ifc1.set_flags  = set_flags;
    assign ifc1.rd_in      = rd_in;

    mul_unit #(.EARLY_TERM(0)) dut_fixed (.Clk(Clk), .Clr(Clr), .bus(ifc0));
    mul_unit #(.EARLY_TERM(1)) dut_early (.Clk(Clk), .Clr(Clr), .bus(ifc1));

    // ---------------- clock / reset ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_cnt = edges of busy time left (0 = idle). Done is the cycle where m_cnt == 1.
    int          m_cnt [2];
    logic [31:0] m_exp [2];
    logic        m_sf  [2];
    logic [3:0]  m_rdl [2];
    logic [31:0] m_res [2];
    logic [3:0]  m_rd  [2];
    logic        m_n   [2];
    logic        m_z   [2];

    function automatic int early_len(input logic [31:0] b);
        int len;
        len = 1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) len = i + 1;
        end
        return len;
    endfunction

    initial begin
        forever begin
            @(posedge Clk or negedge Clr);
            for (int k = 0; k < 2; k++) begin
                if (!Clr) begin
                    m_cnt[k] = 0;
                    m_exp[k] = '0;
                    m_sf[k]  = 1'b0;
                    m_rdl[k] = '0;
                    m_res[k] = '0;
                    m_rd[k]  = '0;
                    m_n[k]   = 1'b0;
                    m_z[k]   = 1'b0;
                end else if (m_cnt[k] == 0) begin
                    if (start) begin
                        m_exp[k] = op_a * op_b + (accumulate ? op_acc : 32'd0);
                        m_sf[k]  = set_flags;
                        m_rdl[k] = rd_in;
                        m_cnt[k] = ((k == 0) ? 32 : early_len(op_b)) + 1;
                    end
                end else begin
                    m_cnt[k] = m_cnt[k] - 1;
                    if (m_cnt[k] == 1) begin
                        m_res[k] = m_exp[k];
                        m_rd[k]  = m_rdl[k];
                        if (m_sf[k]) begin
                            m_n[k] = m_exp[k][31];
                            m_z[k] = (m_exp[k] == 32'd0);
                        end
                    end
                end
            end
        end
    end

    // ---------------- scoreboard compare (every cycle, away from the edge) ----------------
    task automatic cmp_unit(input int k, input logic busy, input logic done, input logic wr_en,
                            input logic [3:0] rd, input logic [31:0] res, input logic n, input logic z);
        string p;
        p = (k == 0) ? "fixed" : "early";
        chk({p, ".busy"},   {31'd0, busy},  {31'd0, m_cnt[k] != 0});
        chk({p, ".done"},   {31'd0, done},  {31'd0, m_cnt[k] == 1});
        chk({p, ".wr_en"},  {31'd0, wr_en}, {31'd0, m_cnt[k] == 1});
        chk({p, ".rd_out"}, {28'd0, rd},    {28'd0, m_rd[k]});
        chk({p, ".result"}, res,            m_res[k]);
        chk({p, ".N"},      {31'd0, n},     {31'd0, m_n[k]});
        chk({p, ".Z"},      {31'd0, z},     {31'd0, m_z[k]});
    endtask

    initial begin
        forever begin
            @(negedge Clk);
            cmp_unit(0, ifc0.busy, ifc0.done, ifc0.wr_en, ifc0.rd_out, ifc0.result, ifc0.N, ifc0.Z);
            cmp_unit(1, ifc1.busy, ifc1.done, ifc1.wr_en, ifc1.rd_out, ifc1.result, ifc1.N, ifc1.Z);
        end
    end

    // ---------------- driver tasks ----------------
    // Issues one op and scrambles the operands after the accepting edge.
    // d0/d1 return the first sample (counting edges after E0) at which each instance shows done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic acc, input logic sf, input logic [3:0] rd,
                          output int d0, output int d1);
        @(negedge Clk);
        op_a = a; op_b = b; op_acc = c; accumulate = acc; set_flags = sf; rd_in = rd;
        start = 1'b1;
        @(negedge Clk);
        start      = 1'b0;
        op_a       = $urandom;
        op_b       = $urandom;
        op_acc     = $urandom;
        accumulate = 1'($urandom_range(0, 1));
        set_flags  = 1'($urandom_range(0, 1));
        rd_in      = 4'($urandom_range(0, 15));
        d0 = -1;
        d1 = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            if (ifc1.done && d1 < 0) d1 = k;
            if (ifc0.done && d0 < 0) d0 = k;
            if (d0 >= 0) break;
        end
        if (d0 < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL op_timeout actual=no_done required=done_by_40");
        end
    endtask

    // ---------------- directed sequence ----------------
    int d0, d1;
    int k0, k1, pulses;

    initial begin
        n_checks = 0; n_errors = 0;
        Clr = 1'b0; start = 1'b0;
        op_a = '0; op_b = '0; op_acc = '0; accumulate = 1'b0; set_flags = 1'b0; rd_in = '0;
        repeat (3) @(negedge Clk);
        chk("reset.busy",   {31'd0, ifc0.busy}, 32'd0);
        chk("reset.result", ifc0.result,        32'd0);
        chk("reset.state",  {30'd0, ifc0.state_dbg}, 32'd0);
        Clr = 1'b1;
        @(negedge Clk);

        // 7 x 6, fixed latency 32, early exits after 3 edges
        run_op(32'd7, 32'd6, 32'd99, 1'b0, 1'b0, 4'h8, d0, d1);
        chk("mul7x6.done_cycle",  d0, 32);
        chk("mul7x6.result",      ifc0.result, 32'd42);
        chk("mul7x6.rd_out",      {28'd0, ifc0.rd_out}, 32'h8);
        chk("mul7x6.early_cycle", d1, 3);
        chk("mul7x6.busy_e33",    {31'd0, ifc0.busy}, 32'd1);
        @(negedge Clk);
        chk("mul7x6.idle_e34",    {31'd0, ifc0.busy}, 32'd0);

        // MLA with wraparound and flags
        run_op(32'hFFFF_FFFF, 32'd2, 32'd5, 1'b1, 1'b1, 4'h2, d0, d1);
        chk("mla.result", ifc0.result, 32'h0000_0003);
        chk("mla.N",      {31'd0, ifc0.N}, 32'd0);
        chk("mla.Z",      {31'd0, ifc0.Z}, 32'd0);

        // zero product sets Z; the next op without set_flags keeps it
        run_op(32'h8000_0000, 32'd2, 32'd0, 1'b0, 1'b1, 4'h3, d0, d1);
        chk("zero.result", ifc0.result, 32'd0);
        chk("zero.Z",      {31'd0, ifc0.Z}, 32'd1);
        chk("zero.N",      {31'd0, ifc0.N}, 32'd0);
        run_op(32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 4'h4, d0, d1);
        chk("noflags.result", ifc0.result, 32'd9);
        chk("noflags.Z_hold", {31'd0, ifc0.Z}, 32'd1);

        // early termination corner cases
        run_op(32'd77, 32'd0, 32'h1234, 1'b1, 1'b0, 4'h5, d0, d1);
        chk("early_b0.cycle",  d1, 1);
        chk("early_b0.result", ifc1.result, 32'h1234);
        run_op(32'd10, 32'd3, 32'd0, 1'b0, 1'b0, 4'h6, d0, d1);
        chk("early_b3.cycle",  d1, 2);
        chk("early_b3.result", ifc1.result, 32'd30);

        // reset in the middle of a run
        @(negedge Clk);
        op_a = 32'd5; op_b = 32'd7; accumulate = 1'b0; set_flags = 1'b1; rd_in = 4'h7;
        start = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
        repeat (10) @(posedge Clk);
        #1 Clr = 1'b0;
        #1;
        chk("abort.busy",   {31'd0, ifc0.busy},  32'd0);
        chk("abort.wr_en",  {31'd0, ifc0.wr_en}, 32'd0);
        chk("abort.result", ifc0.result,         32'd0);
        chk("abort.rd_out", {28'd0, ifc0.rd_out}, 32'd0);
        chk("abort.state",  {30'd0, ifc0.state_dbg}, 32'd0);
        repeat (2) @(negedge Clk);
        Clr = 1'b1;
        pulses = 0;
        for (int k = 0; k < 35; k++) begin
            @(negedge Clk);
            if (ifc0.wr_en) pulses++;
        end
        chk("abort.no_wr_pulse", pulses, 0);
        run_op(32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 4'h1, d0, d1);
        chk("post_reset.result", ifc0.result, 32'd9);

        // start pulsed during RUN and held: the first op is unaffected and the second starts right after done
        @(negedge Clk);
        op_a = 32'd11; op_b = 32'd13; accumulate = 1'b0; set_flags = 1'b0; rd_in = 4'h3;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        op_a = 32'd100; op_b = 32'd5; rd_in = 4'h9;
        repeat (4) @(negedge Clk);
        start = 1'b1;
        k0 = -1; k1 = -1;
        for (int k = 5; k <= 80; k++) begin
            @(negedge Clk);
            if (ifc0.done) begin
                if (k0 < 0) begin
                    k0 = k;
                    chk("held.first_result", ifc0.result, 32'd143);
                    chk("held.first_rd",     {28'd0, ifc0.rd_out}, 32'h3);
                end else begin
                    k1 = k;
                    chk("held.second_result", ifc0.result, 32'd500);
                    chk("held.second_rd",     {28'd0, ifc0.rd_out}, 32'h9);
                    break;
                end
            end
        end
        start = 1'b0;
        chk("held.first_cycle",  k0, 32);
        chk("held.second_cycle", k1, 66);
        repeat (40) @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mul_unit.md
MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 The block SHALL have parameter EARLY_TERM, default 0: 0 gives fixed 32-iteration latency; 1 ends the operation once the remaining multiplier bits are zero.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Clr, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a new multiply; sampled only in IDLE.
REQ-005 The block SHALL have port op_a, input, 32 bits: multiplicand Rm, driven from register-file Port A.
REQ-006 The block SHALL have port op_b, input, 32 bits: multiplier Rs, driven from register-file Port B.
REQ-007 The block SHALL have port op_acc, input, 32 bits: accumulate operand Rn (MLA).
REQ-008 The block SHALL have port accumulate, input, 1 bit: 1 = MLA, 0 = MUL.
REQ-009 The block SHALL have port set_flags, input, 1 bit: S bit; update N/Z on completion.
REQ-010 The block SHALL have port rd_in, input, 4 bits: destination register index.
REQ-011 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port wr_en, output, 1 bit: register-file write enable, active-high, feeding the decoder enable; equal to done.
REQ-014 The block SHALL have port rd_out, output, 4 bits: latched rd_in, feeding the decoder select.
REQ-015 The block SHALL have port result, output, 32 bits: product (plus Rn) mod 2^32, feeding register-file write data.
REQ-016 The block SHALL have ports N and Z, output, 1 bit each: condition flags.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-018 On a rising edge in IDLE with start=1, the block SHALL latch op_a into the multiplicand, op_b into the multiplier, rd_in, accumulate and set_flags; load the accumulator with op_acc if accumulate=1, else 0; clear the iteration count; and go to RUN. Call this edge E0.
REQ-019 Each RUN edge SHALL add the multiplicand to the accumulator when multiplier bit 0 is 1, shift the multiplicand left 1, shift the multiplier right logically 1, and increment the count; all arithmetic is 32-bit and discards carries.
REQ-020 With EARLY_TERM=0, RUN SHALL last exactly 32 edges (E1..E32), and the block SHALL enter DONE at E32.
REQ-021 With EARLY_TERM=1, the block SHALL enter DONE on the first RUN edge where the shifted multiplier is zero or the count reaches 32; op_b=0 SHALL give DONE at E1 with result=accumulator initial value.
REQ-022 On entry to DONE, result SHALL take the final accumulator value, and if the latched set_flags=1 then N=result[31] and Z=(result==0); otherwise N and Z SHALL hold.
REQ-023 In DONE, done and wr_en SHALL be 1 for exactly one cycle, and the next edge SHALL return the FSM to IDLE.
REQ-024 result and rd_out SHALL hold their values until the next entry to DONE.
REQ-025 start in RUN or DONE SHALL be ignored: no queuing, and latched operands SHALL be unchanged.
REQ-026 start held high SHALL begin a new operation on the first IDLE edge, i.e. one cycle after done.
REQ-027 Operand inputs SHALL be don't-care after E0.
REQ-028 The result SHALL be identical for signed and unsigned interpretations (low 32 bits only).

Reset
REQ-029 While Clr=0, asynchronously, the state SHALL be IDLE and busy, done, wr_en, rd_out, result, N, Z, the accumulator and the count SHALL all be 0.
REQ-030 Reset asserted in RUN or DONE SHALL abort the operation with no wr_en pulse; the first start after Clr returns to 1 SHALL operate normally.

Verification
REQ-031 EARLY_TERM=0, op_a=7, op_b=6, accumulate=0, rd_in=4'h8 -> result=42, done/wr_en high only in the cycle after E32, rd_out=4'h8, busy high E0..E33.
REQ-032 MLA op_a=32'hFFFFFFFF, op_b=2, op_acc=5, set_flags=1 -> result=32'h00000003, N=0, Z=0.
REQ-033 op_a=32'h80000000, op_b=2, set_flags=1 -> result=0, Z=1, N=0; a following multiply with set_flags=0 leaves Z=1.
REQ-034 EARLY_TERM=1, op_b=0, accumulate=1, op_acc=32'h1234 -> done in the cycle after E1, result=32'h1234; op_b=3 -> DONE at E2.
REQ-035 Clr pulsed low at E10 of a run -> all outputs 0 immediately, no wr_en pulse; a new 3x3 run -> result=9.
REQ-036 start pulsed at E5 and held through DONE -> first operation unaffected; the second begins at the IDLE edge after done.
